// File: rtl/powlib_pkg.sv
// powlib_pkg: shared helpers for the powlib dual-port RAM arbiter.
//   clog2   - ceiling log2 for deriving pointer / address widths
//   oh_enc  - one-hot to index encoder (up to MAX_N requesters)
//   rtag_t  - read-tag carried alongside an outstanding RAM read
package powlib_pkg;

  localparam int MAX_N = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } rtag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic [2:0] oh_enc(input logic [MAX_N-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) r = r | 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/powlib_rrarb.sv
// powlib_rrarb: round-robin arbiter with a rotating priority pointer.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset (pointer -> 0)
//   req_i  - request vector
//   gnt_o  - one-hot grant, first request at or after the pointer
//   gvld_o - any grant this cycle
// After granting index g the pointer moves to (g+1) mod N; it holds when idle.
module powlib_rrarb
  import powlib_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         gvld_o
);

  localparam int PW = clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic [PW:0]   s;
  logic [PW:0]   nxt;
  logic          found;

  // Cyclic search starting at the pointer; s carries one spare bit so the
  // wrap works for non-power-of-two N.
  always_comb begin
    gnt_o = '0;
    gidx  = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr_q} + (PW+1)'(k);
      if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
      if (!found && req_i[s[PW-1:0]]) begin
        found              = 1'b1;
        gnt_o[s[PW-1:0]]   = 1'b1;
        gidx               = s[PW-1:0];
      end
    end
  end

  assign gvld_o = found;

  always_comb begin
    nxt   = {1'b0, gidx} + (PW+1)'(1);
    ptr_d = ptr_q;
    if (found) ptr_d = (nxt == (PW+1)'(N)) ? '0 : nxt[PW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/powlib_dpram_arb.sv
// powlib_dpram_arb: shares one external dual-port RAM between N requesters.
// Write and read ports are arbitrated independently by two round-robin
// arbiters; read responses are routed back one-hot after ERRD+1 cycles.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   in_vld_i/in_op_i        - per-requester valid and op (1 = write, 0 = read)
//   in_addr_i/data_i/be_i   - flattened per-requester address, data, byte enables
//   in_rdy_o                - request accepted (granted by either arbiter)
//   out_vld_o/out_data_o    - one-hot read response valid, broadcast data
//   wr_vld_o/addr/data/be   - RAM write port
//   rd_addr_o, rd_data_i    - RAM read port
module powlib_dpram_arb
  import powlib_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 32,
  parameter  int D    = 4,
  parameter  int EWBE = 0,
  parameter  int ERRD = 1,
  localparam int AW   = clog2(D),
  localparam int BW   = W / 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    in_vld_i,
  output logic [N-1:0]    in_rdy_o,
  input  logic [N-1:0]    in_op_i,
  input  logic [N*AW-1:0] in_addr_i,
  input  logic [N*W-1:0]  in_data_i,
  input  logic [N*BW-1:0] in_be_i,
  output logic [N-1:0]    out_vld_o,
  output logic [W-1:0]    out_data_o,
  output logic            wr_vld_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [W-1:0]    wr_data_o,
  output logic [BW-1:0]   wr_be_o,
  output logic [AW-1:0]   rd_addr_o,
  input  logic [W-1:0]    rd_data_i
);

  logic [N-1:0]     wreq, rreq, wgnt, rgnt;
  logic             wgv, rgv;
  logic [BW-1:0]    be_sel;
  logic [MAX_N-1:0] rgnt8;
  rtag_t            tag_d, tail;
  rtag_t            pipe_q [ERRD:0];

  // Requests are masked during reset so nothing is granted or written.
  assign wreq = rst_i ? '0 : (in_vld_i &  in_op_i);
  assign rreq = rst_i ? '0 : (in_vld_i & ~in_op_i);

  powlib_rrarb #(.N(N)) u_warb (
    .clk_i (clk_i), .rst_i (rst_i), .req_i (wreq), .gnt_o (wgnt), .gvld_o (wgv)
  );

  powlib_rrarb #(.N(N)) u_rarb (
    .clk_i (clk_i), .rst_i (rst_i), .req_i (rreq), .gnt_o (rgnt), .gvld_o (rgv)
  );

  assign in_rdy_o = wgnt | rgnt;
  assign wr_vld_o = wgv;

  // One-hot grant muxes for both RAM ports.
  always_comb begin
    wr_addr_o = '0;
    wr_data_o = '0;
    be_sel    = '0;
    rd_addr_o = '0;
    for (int i = 0; i < N; i++) begin
      if (wgnt[i]) begin
        wr_addr_o = in_addr_i[i*AW +: AW];
        wr_data_o = in_data_i[i*W +: W];
        be_sel    = in_be_i[i*BW +: BW];
      end
      if (rgnt[i]) rd_addr_o = in_addr_i[i*AW +: AW];
    end
  end

  if (EWBE != 0) begin : g_be
    assign wr_be_o = be_sel;
  end else begin : g_nobe
    logic be_unused;
    assign be_unused = ^be_sel;
    assign wr_be_o   = '1;
  end

  // Read-tag pipe: depth tracks the RAM read latency so the tail lines up
  // with rd_data_i.
  assign rgnt8     = MAX_N'(rgnt);
  assign tag_d.vld = rgv;
  assign tag_d.idx = oh_enc(rgnt8);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s <= ERRD; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= tag_d;
      for (int s = 1; s <= ERRD; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign tail = pipe_q[ERRD];

  // Gated by rst_i so a read accepted just before reset never responds,
  // even with the single-stage pipe.
  always_comb begin
    out_vld_o = '0;
    for (int i = 0; i < N; i++)
      out_vld_o[i] = tail.vld && !rst_i && (tail.idx == 3'(i));
  end

  assign out_data_o = rd_data_i;

endmodule

// File: tb/tb_powlib_dpram_arb.sv
// Bench for powlib_dpram_arb. Two instances share one stimulus stream:
//   dut A: EWBE=1, ERRD=1 (table expectations written for this one)
//   dut B: EWBE=0, ERRD=0 (same grants, responses one cycle earlier, wr_be all-ones)
// Each instance has its own read-first RAM model.
module tb_powlib_dpram_arb;

  logic         clk, rst, ld;
  logic [3:0]   in_vld, in_op;
  logic [7:0]   in_addr;
  logic [127:0] in_data;
  logic [15:0]  in_be;

  logic [3:0]  a_rdy, a_ov, a_wbe, b_rdy, b_ov, b_wbe;
  logic [31:0] a_od, a_wd, a_rd, b_od, b_wd, b_rd;
  logic        a_wv, b_wv;
  logic [1:0]  a_wa, a_ra, b_wa, b_ra;

  logic [31:0] memA [4];
  logic [31:0] memB [4];
  logic [31:0] qa1, qa2, qb1;

  int nerr = 0;
  int nchk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  powlib_dpram_arb #(.N(4), .W(32), .D(4), .EWBE(1), .ERRD(1)) u_a (
    .clk_i(clk), .rst_i(rst), .in_vld_i(in_vld), .in_rdy_o(a_rdy), .in_op_i(in_op),
    .in_addr_i(in_addr), .in_data_i(in_data), .in_be_i(in_be),
    .out_vld_o(a_ov), .out_data_o(a_od), .wr_vld_o(a_wv), .wr_addr_o(a_wa),
    .wr_data_o(a_wd), .wr_be_o(a_wbe), .rd_addr_o(a_ra), .rd_data_i(a_rd)
  );

  powlib_dpram_arb #(.N(4), .W(32), .D(4), .EWBE(0), .ERRD(0)) u_b (
    .clk_i(clk), .rst_i(rst), .in_vld_i(in_vld), .in_rdy_o(b_rdy), .in_op_i(in_op),
    .in_addr_i(in_addr), .in_data_i(in_data), .in_be_i(in_be),
    .out_vld_o(b_ov), .out_data_o(b_od), .wr_vld_o(b_wv), .wr_addr_o(b_wa),
    .wr_data_o(b_wd), .wr_be_o(b_wbe), .rd_addr_o(b_ra), .rd_data_i(b_rd)
  );

  // Read-first RAM models: A has a 2-cycle read, B a 1-cycle read.
  always @(posedge clk) begin
    if (ld) begin
      memA <= '{32'h00001234, 32'h00005678, 32'h0000CBA9, 32'h00000FED};
      memB <= '{32'h00001234, 32'h00005678, 32'h0000CBA9, 32'h00000FED};
    end else begin
      if (a_wv)
        for (int b = 0; b < 4; b++)
          if (a_wbe[b]) memA[a_wa][8*b +: 8] <= a_wd[8*b +: 8];
      if (b_wv)
        for (int b = 0; b < 4; b++)
          if (b_wbe[b]) memB[b_wa][8*b +: 8] <= b_wd[8*b +: 8];
    end
    qa1 <= memA[a_ra];
    qa2 <= qa1;
    qb1 <= memB[b_ra];
  end

  assign a_rd = qa2;
  assign b_rd = qb1;

  typedef struct packed {
    logic         rst;
    logic         ld;
    logic [3:0]   vld;
    logic [3:0]   op;
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic [3:0]   rdy;
    logic         wv;
    logic [1:0]   wa;
    logic [31:0]  wd;
    logic [3:0]   wbe;
    logic         rg;
    logic [1:0]   ra;
    logic [3:0]   ov;
    logic [31:0]  od;
  } vec_t;

  localparam int NV = 40;
  vec_t tv [NV];

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] v,
                              input logic [3:0] o, input logic [7:0] a,
                              input logic [3:0] rdy, input logic wv,
                              input logic [1:0] wa, input logic [31:0] wd,
                              input logic rg, input logic [1:0] ra,
                              input logic [3:0] ov, input logic [31:0] od);
    vec_t t;
    t.rst = r;  t.ld = l;  t.vld = v;  t.op = o;  t.addr = a;
    t.data = {32'h00001003, 32'h00001002, 32'h00001001, 32'h00001000};
    t.be = 16'hFFFF;  t.wbe = 4'hF;
    t.rdy = rdy;  t.wv = wv;  t.wa = wa;  t.wd = wd;
    t.rg = rg;  t.ra = ra;  t.ov = ov;  t.od = od;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  localparam logic Z = 1'b0;
  localparam logic O = 1'b1;

  initial begin
    rst = 1'b1;  ld = 1'b0;  in_vld = '0;  in_op = '0;
    in_addr = '0;  in_data = '0;  in_be = '1;

    //            rst ld vld   op    addr   rdy  wv wa     wd            rg ra     ov    od
    // reset, then write fairness
    tv[0]  = mk(O, O, 4'hF, 4'hF, 8'hE4, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[1]  = mk(Z, Z, 4'hF, 4'hF, 8'hE4, 4'h1, O, 2'd0, 32'h00001000, Z, 2'd0, 4'h0, 32'h0);
    tv[2]  = mk(Z, Z, 4'hE, 4'hF, 8'hE4, 4'h2, O, 2'd1, 32'h00001001, Z, 2'd0, 4'h0, 32'h0);
    tv[3]  = mk(Z, Z, 4'hC, 4'hF, 8'hE4, 4'h4, O, 2'd2, 32'h00001002, Z, 2'd0, 4'h0, 32'h0);
    tv[4]  = mk(Z, Z, 4'h8, 4'hF, 8'hE4, 4'h8, O, 2'd3, 32'h00001003, Z, 2'd0, 4'h0, 32'h0);
    tv[5]  = mk(Z, Z, 4'h0, 4'h0, 8'hE4, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    // read back addresses 0..3
    tv[6]  = mk(Z, Z, 4'h1, 4'h0, 8'hE4, 4'h1, Z, 2'd0, 32'h0,        O, 2'd0, 4'h0, 32'h0);
    tv[7]  = mk(Z, Z, 4'h2, 4'h0, 8'hE4, 4'h2, Z, 2'd0, 32'h0,        O, 2'd1, 4'h0, 32'h0);
    tv[8]  = mk(Z, Z, 4'h4, 4'h0, 8'hE4, 4'h4, Z, 2'd0, 32'h0,        O, 2'd2, 4'h1, 32'h00001000);
    tv[9]  = mk(Z, Z, 4'h8, 4'h0, 8'hE4, 4'h8, Z, 2'd0, 32'h0,        O, 2'd3, 4'h2, 32'h00001001);
    tv[10] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h4, 32'h00001002);
    tv[11] = mk(Z, O, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h8, 32'h00001003);
    // read latency: requester 2 reads addr 1
    tv[12] = mk(Z, Z, 4'h4, 4'h0, 8'h10, 4'h4, Z, 2'd0, 32'h0,        O, 2'd1, 4'h0, 32'h0);
    tv[13] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[14] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h4, 32'h00005678);
    tv[15] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    // concurrent write/read of addr 3, read-first
    tv[16] = mk(Z, Z, 4'h3, 4'h1, 8'h0F, 4'h3, O, 2'd3, 32'h0000AAAA, O, 2'd3, 4'h0, 32'h0);
    tv[17] = mk(Z, Z, 4'h2, 4'h0, 8'h0F, 4'h2, Z, 2'd0, 32'h0,        O, 2'd3, 4'h0, 32'h0);
    tv[18] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h2, 32'h00000FED);
    tv[19] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h2, 32'h0000AAAA);
    // byte enables on addr 0
    tv[20] = mk(Z, Z, 4'h1, 4'h1, 8'h00, 4'h1, O, 2'd0, 32'hFFFFFFFF, Z, 2'd0, 4'h0, 32'h0);
    tv[21] = mk(Z, Z, 4'h8, 4'h0, 8'h00, 4'h8, Z, 2'd0, 32'h0,        O, 2'd0, 4'h0, 32'h0);
    tv[22] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[23] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h8, 32'h0000FFFF);
    // pointer skip: only 1 and 3 read
    tv[24] = mk(Z, Z, 4'hA, 4'h0, 8'hC8, 4'h2, Z, 2'd0, 32'h0,        O, 2'd2, 4'h0, 32'h0);
    tv[25] = mk(Z, Z, 4'hA, 4'h0, 8'hC8, 4'h8, Z, 2'd0, 32'h0,        O, 2'd3, 4'h0, 32'h0);
    tv[26] = mk(Z, Z, 4'hA, 4'h0, 8'hC8, 4'h2, Z, 2'd0, 32'h0,        O, 2'd2, 4'h2, 32'h0000CBA9);
    tv[27] = mk(Z, Z, 4'hA, 4'h0, 8'hC8, 4'h8, Z, 2'd0, 32'h0,        O, 2'd3, 4'h8, 32'h0000AAAA);
    tv[28] = mk(Z, Z, 4'hA, 4'h0, 8'hC8, 4'h2, Z, 2'd0, 32'h0,        O, 2'd2, 4'h2, 32'h0000CBA9);
    tv[29] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h8, 32'h0000AAAA);
    tv[30] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h2, 32'h0000CBA9);
    tv[31] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    // reset mid-flight: read by 2, then rst; pointers restart at 0
    tv[32] = mk(Z, Z, 4'h4, 4'h0, 8'h00, 4'h4, Z, 2'd0, 32'h0,        O, 2'd0, 4'h0, 32'h0);
    tv[33] = mk(O, Z, 4'hF, 4'h5, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[34] = mk(Z, Z, 4'hF, 4'h3, 8'h31, 4'h5, O, 2'd1, 32'h12345678, O, 2'd3, 4'h0, 32'h0);
    tv[35] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[36] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h4, 32'h0000AAAA);
    tv[37] = mk(Z, Z, 4'h1, 4'h0, 8'h01, 4'h1, Z, 2'd0, 32'h0,        O, 2'd1, 4'h0, 32'h0);
    tv[38] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h0, 32'h0);
    tv[39] = mk(Z, Z, 4'h0, 4'h0, 8'h00, 4'h0, Z, 2'd0, 32'h0,        Z, 2'd0, 4'h1, 32'h12345678);

    tv[16].data[31:0] = 32'h0000AAAA;
    tv[20].data[31:0] = 32'hFFFFFFFF;
    tv[20].be[3:0]    = 4'b0011;
    tv[20].wbe        = 4'b0011;
    tv[34].data[31:0] = 32'h12345678;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst = tv[k].rst;  ld = tv[k].ld;  in_vld = tv[k].vld;  in_op = tv[k].op;
      in_addr = tv[k].addr;  in_data = tv[k].data;  in_be = tv[k].be;
      #2;
      chk($sformatf("r%0d a.in_rdy", k), 32'(a_rdy), 32'(tv[k].rdy));
      chk($sformatf("r%0d b.in_rdy", k), 32'(b_rdy), 32'(tv[k].rdy));
      chk($sformatf("r%0d a.wr_vld", k), 32'(a_wv), 32'(tv[k].wv));
      if (tv[k].wv) begin
        chk($sformatf("r%0d a.wr_addr", k), 32'(a_wa), 32'(tv[k].wa));
        chk($sformatf("r%0d a.wr_data", k), a_wd, tv[k].wd);
        chk($sformatf("r%0d a.wr_be", k), 32'(a_wbe), 32'(tv[k].wbe));
        chk($sformatf("r%0d b.wr_be", k), 32'(b_wbe), 32'hF);
      end
      if (tv[k].rg) chk($sformatf("r%0d a.rd_addr", k), 32'(a_ra), 32'(tv[k].ra));
      chk($sformatf("r%0d a.out_vld", k), 32'(a_ov), 32'(tv[k].ov));
      if (tv[k].ov != 4'h0) chk($sformatf("r%0d a.out_data", k), a_od, tv[k].od);
      if (k + 1 < NV) chk($sformatf("r%0d b.out_vld", k), 32'(b_ov), 32'(tv[k+1].ov));
    end

    // All four hold reads: read pointer sits at 1, so grants rotate 1,2,3,0,...
    begin
      int cnt [4];
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        rst = 1'b0;  ld = 1'b0;  in_vld = 4'hF;  in_op = 4'h0;  in_addr = 8'hE4;
        #2;
        chk($sformatf("fair c%0d in_rdy", c), 32'(a_rdy), 32'(4'b0001 << ((c + 1) % 4)));
        for (int i = 0; i < 4; i++) cnt[i] += int'(a_rdy[i]);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("fair grants req%0d", i), 32'(cnt[i]), 32'd2);
    end

    @(negedge clk);
    in_vld = '0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
